dma_job_sched: RTL and testbench

Descriptor-queue scheduler that sequences the duplex AXIS DMA on behalf of the CPU.
- Software pushes RX (memory->CGRA) and TX (CGRA->memory) jobs through MMIO into two per-direction queues.
- For each direction independently, the block launches one job at a time on the DMA start/addr/len inputs, then detects completion from the DMA busy flag.
- It counts completed jobs and raises an interrupt pulse.
- It sits between the MMIO register decode and axis_dma_duplex, replacing direct CPU writes of start/src/dst/len.

---
 rtl/dma_job_sched_pkg.sv | 32 +++
 rtl/dma_job_sched_if.sv | 33 +++
 rtl/dma_job_sched_fifo.sv | 53 +++++
 rtl/dma_job_sched.sv | 133 +++++++++++++
 tb/tb_dma_job_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dma_job_sched_pkg.sv
// Shared types and constants for the DMA job scheduler: descriptor payload,
// per-direction FSM states, direction indices and parameter defaults.
package dma_sched_pkg;

  localparam int unsigned ADDR_W          = 64;
  localparam int unsigned LEN_W           = 32;
  localparam int unsigned QDEPTH_DEF      = 4;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned ALIGN_BYTES_DEF = 8;
  localparam int unsigned NDIR            = 2;
  localparam int unsigned DIR_RX          = 0;
  localparam int unsigned DIR_TX          = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } dma_desc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // align must be a power of two
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       align);
    return (addr & ADDR_W'(align - 1)) == '0;
  endfunction

endpackage

// File: rtl/dma_job_sched_if.sv
// Descriptor push channel plus the duplex DMA start/addr/len/busy control bundle.
interface dma_job_sched_if;
  import dma_sched_pkg::*;

  logic              desc_valid;
  logic              desc_ready;
  logic              desc_dir;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;

  logic              start_rx;
  logic [ADDR_W-1:0] src_addr_rx;
  logic [LEN_W-1:0]  len_pkts_rx;
  logic              busy_rx;
  logic              start_tx;
  logic [ADDR_W-1:0] dst_addr_tx;
  logic [LEN_W-1:0]  len_pkts_tx;
  logic              busy_tx;

  // master: MMIO decode + DMA engine side; slave: the scheduler
  modport master (
    output desc_valid, desc_dir, desc_addr, desc_len, busy_rx, busy_tx,
    input  desc_ready, start_rx, src_addr_rx, len_pkts_rx,
           start_tx, dst_addr_tx, len_pkts_tx
  );

  modport slave (
    input  desc_valid, desc_dir, desc_addr, desc_len, busy_rx, busy_tx,
    output desc_ready, start_rx, src_addr_rx, len_pkts_rx,
           start_tx, dst_addr_tx, len_pkts_tx
  );

endinterface

// File: rtl/dma_job_sched_fifo.sv
// Descriptor FIFO with wrap-bit pointers, full/empty, occupancy and a
// single-cycle flush that empties the queue.
module dma_desc_fifo
  import dma_sched_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  dma_desc_t                    wr_data,
  output dma_desc_t                    rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH+1);

  logic [PW:0] wr_ptr_q, rd_ptr_q;
  dma_desc_t   mem_q [QDEPTH];
  logic        push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count   = CW'(wr_ptr_q - rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[PW-1:0]];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // storage needs no reset: entries are only read behind the write pointer
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dma_job_sched.sv
// Two independent descriptor queues, each feeding a launch/run/done FSM that
// drives one direction of the duplex AXIS DMA and counts completions.
module dma_job_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned QDEPTH      = QDEPTH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned ALIGN_BYTES = ALIGN_BYTES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  dma_job_sched_if.slave               bus,
  input  logic                         flush,
  input  logic                         irq_en,
  input  logic                         err_clr,
  output logic [$clog2(QDEPTH+1)-1:0]  pend_rx,
  output logic [$clog2(QDEPTH+1)-1:0]  pend_tx,
  output logic [CNT_W-1:0]             cmpl_cnt_rx,
  output logic [CNT_W-1:0]             cmpl_cnt_tx,
  output logic                         irq,
  output logic                         err
  ,output logic                        idle
);

  localparam int unsigned CW = $clog2(QDEPTH+1);

  logic [NDIR-1:0] push_v, pop_v, full_v, done_v, idle_v;
  logic            accept, aligned;
  dma_desc_t       wr_desc;
  logic            irq_q, err_q;

  assign wr_desc        = '{addr: bus.desc_addr, len: bus.desc_len};
  assign aligned        = is_aligned(bus.desc_addr, ALIGN_BYTES);
  assign bus.desc_ready = !full_v[bus.desc_dir] && !flush;
  assign accept         = bus.desc_valid && bus.desc_ready;

  for (genvar d = 0; d < NDIR; d++) begin : g_dir
    sched_state_e      state_q;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy, empty, full;
    dma_desc_t         head;
    logic [CW-1:0]     occ;

    // misaligned descriptors complete the handshake but never enter a queue
    assign push_v[d] = accept && aligned && (bus.desc_dir == 1'(d));
    assign pop_v[d]  = (state_q == IDLE) && !empty;
    assign full_v[d] = full;
    assign done_v[d] = (state_q == DONE);
    assign idle_v[d] = (state_q == IDLE) && empty;

    dma_desc_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_v[d]),
      .pop     (pop_v[d]),
      .flush   (flush),
      .wr_data (wr_desc),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (occ)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        start_q <= 1'b0;
        addr_q  <= '0;
        len_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (!empty) begin
            addr_q <= head.addr;
            len_q  <= head.len;
            // zero-length jobs complete without touching the DMA
            if (head.len != '0) begin
              start_q <= 1'b1;
              state_q <= LAUNCH;
            end else begin
              state_q <= DONE;
            end
          end
          LAUNCH: if (busy) begin
            start_q <= 1'b0;
            state_q <= RUN;
          end
          RUN: if (!busy) state_q <= DONE;
          DONE: begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    if (d == DIR_RX) begin : g_rx
      assign busy            = bus.busy_rx;
      assign bus.start_rx    = start_q;
      assign bus.src_addr_rx = addr_q;
      assign bus.len_pkts_rx = len_q;
      assign pend_rx         = occ;
      assign cmpl_cnt_rx     = cnt_q;
    end else begin : g_tx
      assign busy            = bus.busy_tx;
      assign bus.start_tx    = start_q;
      assign bus.dst_addr_tx = addr_q;
      assign bus.len_pkts_tx = len_q;
      assign pend_tx         = occ;
      assign cmpl_cnt_tx     = cnt_q;
    end
  end

  // simultaneous RX/TX completions merge into one pulse; error set beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      irq_q <= irq_en && (|done_v);
      err_q <= (accept && !aligned) || (err_q && !err_clr);
    end
  end

  assign irq  = irq_q;
  assign err  = err_q;
  assign idle = &idle_v;

endmodule

// File: tb/tb_dma_job_sched.sv
// Directed bench for dma_job_sched: single job, queue full, concurrent
// completion, zero length / misalignment, flush and reset during launch.
module tb_dma_job_sched;
  import dma_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0, irq_en = 1'b1, err_clr = 1'b0;
  logic [2:0]  pend_rx, pend_tx;
  logic [15:0] cmpl_cnt_rx, cmpl_cnt_tx;
  logic        irq, err, idle;
  logic        man_busy_rx = 1'b0, man_busy_tx = 1'b0, mdl_busy_rx = 1'b0, auto_rx = 1'b0;
  int          total = 0, bad = 0;
  int          exp_rx = 0, exp_tx = 0;

  always #5 clk = ~clk;

  dma_job_sched_if bus();
  assign bus.busy_rx = auto_rx ? mdl_busy_rx : man_busy_rx;
  assign bus.busy_tx = man_busy_tx;

  dma_job_sched dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush), .irq_en(irq_en), .err_clr(err_clr),
    .pend_rx(pend_rx), .pend_tx(pend_tx), .cmpl_cnt_rx(cmpl_cnt_rx), .cmpl_cnt_tx(cmpl_cnt_tx),
    .irq(irq), .err(err), .idle(idle)
  );

  // RX DMA stand-in: busy follows start by one half cycle, lasts one cycle
  initial forever begin
    @(negedge clk);
    if (!auto_rx) mdl_busy_rx = 1'b0;
    else if (bus.start_rx && !mdl_busy_rx) mdl_busy_rx = 1'b1;
    else if (!bus.start_rx && mdl_busy_rx) mdl_busy_rx = 1'b0;
  end

  task automatic push(input logic dir, input logic [63:0] addr, input logic [31:0] len,
                      output logic acc);
    bus.desc_valid = 1'b1; bus.desc_dir = dir; bus.desc_addr = addr; bus.desc_len = len;
    #1 acc = bus.desc_ready;
    @(negedge clk);
    bus.desc_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if ({bus.start_rx, bus.start_tx, irq, err, pend_rx, pend_tx} !== 10'd0) begin
      bad++; $display("FAIL reset_zero got=%b exp=0", {bus.start_rx, bus.start_tx, irq, err, pend_rx, pend_tx}); end
    total++; if ({bus.desc_ready, idle} !== 2'b11) begin
      bad++; $display("FAIL reset_ready_idle got=%b exp=11", {bus.desc_ready, idle}); end
    total++; if ({cmpl_cnt_rx, cmpl_cnt_tx, bus.src_addr_rx, bus.len_pkts_tx} !== '0) begin
      bad++; $display("FAIL reset_cnt_addr got rx=%0d tx=%0d src=%h", cmpl_cnt_rx, cmpl_cnt_tx, bus.src_addr_rx); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_rx;
    logic acc;
    push(1'b0, 64'h100, 32'd3, acc);
    total++; if (acc !== 1'b1 || pend_rx !== 3'd1 || bus.start_rx !== 1'b0) begin
      bad++; $display("FAIL t1_accept got acc=%b pend=%0d start=%b exp 1/1/0", acc, pend_rx, bus.start_rx); end
    @(negedge clk);
    total++; if (bus.start_rx !== 1'b1 || bus.src_addr_rx !== 64'h100 || bus.len_pkts_rx !== 32'd3 || pend_rx !== 3'd0) begin
      bad++; $display("FAIL t1_launch got start=%b addr=%h len=%0d pend=%0d", bus.start_rx, bus.src_addr_rx, bus.len_pkts_rx, pend_rx); end
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.start_rx !== 1'b1) begin
      bad++; $display("FAIL t1_start_hold got=%b exp=1", bus.start_rx); end
    man_busy_rx = 1'b1;
    @(negedge clk);
    total++; if (bus.start_rx !== 1'b0) begin
      bad++; $display("FAIL t1_start_drop got=%b exp=0", bus.start_rx); end
    repeat (9) @(negedge clk);
    man_busy_rx = 1'b0;
    @(negedge clk);
    total++; if (irq !== 1'b0 || cmpl_cnt_rx !== 16'd0) begin
      bad++; $display("FAIL t1_done_cycle got irq=%b cnt=%0d exp 0/0", irq, cmpl_cnt_rx); end
    @(negedge clk);
    exp_rx++;
    total++; if (irq !== 1'b1 || cmpl_cnt_rx !== 16'(exp_rx)) begin
      bad++; $display("FAIL t1_complete got irq=%b cnt=%0d exp 1/%0d", irq, cmpl_cnt_rx, exp_rx); end
    @(negedge clk);
    total++; if (irq !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL t1_pulse_end got irq=%b idle=%b exp 0/1", irq, idle); end
  endtask

  task automatic test_queue_full;
    logic acc;
    logic [2:0] exp_pend [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    man_busy_rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 64'h200 + 64'(i * 8), 32'd1, acc);
      total++; if (acc !== 1'b1 || pend_rx !== exp_pend[i]) begin
        bad++; $display("FAIL t2_push%0d got acc=%b pend=%0d exp 1/%0d", i, acc, pend_rx, exp_pend[i]); end
    end
    push(1'b0, 64'h300, 32'd1, acc);
    total++; if (acc !== 1'b0 || pend_rx !== 3'd4) begin
      bad++; $display("FAIL t2_full got acc=%b pend=%0d exp 0/4", acc, pend_rx); end
    push(1'b1, 64'h1000, 32'd0, acc);
    exp_tx++;
    total++; if (acc !== 1'b1) begin
      bad++; $display("FAIL t2_tx_while_rx_full got acc=%b exp=1", acc); end
    man_busy_rx = 1'b0;
    auto_rx = 1'b1;
    for (int i = 0; i < 200 && idle !== 1'b1; i++) @(negedge clk);
    auto_rx = 1'b0;
    exp_rx += 5;
    total++; if (idle !== 1'b1) begin
      bad++; $display("FAIL t2_drain_timeout got idle=%b exp=1", idle); end
    total++; if (cmpl_cnt_rx !== 16'(exp_rx) || cmpl_cnt_tx !== 16'(exp_tx) || pend_rx !== 3'd0) begin
      bad++; $display("FAIL t2_counts got rx=%0d tx=%0d pend=%0d exp %0d/%0d/0", cmpl_cnt_rx, cmpl_cnt_tx, pend_rx, exp_rx, exp_tx); end
    @(negedge clk);
  endtask

  task automatic test_concurrent;
    logic acc;
    push(1'b0, 64'h300, 32'd2, acc);
    push(1'b1, 64'h400, 32'd2, acc);
    @(negedge clk);
    total++; if (bus.start_rx !== 1'b1 || bus.start_tx !== 1'b1 || bus.dst_addr_tx !== 64'h400 || bus.len_pkts_tx !== 32'd2) begin
      bad++; $display("FAIL t3_both_start got rx=%b tx=%b addr=%h len=%0d", bus.start_rx, bus.start_tx, bus.dst_addr_tx, bus.len_pkts_tx); end
    man_busy_rx = 1'b1; man_busy_tx = 1'b1;
    @(negedge clk);
    total++; if (bus.start_rx !== 1'b0 || bus.start_tx !== 1'b0) begin
      bad++; $display("FAIL t3_start_drop got rx=%b tx=%b exp 0/0", bus.start_rx, bus.start_tx); end
    @(negedge clk);
    man_busy_rx = 1'b0; man_busy_tx = 1'b0;
    @(negedge clk);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL t3_no_early_irq got=%b exp=0", irq); end
    @(negedge clk);
    exp_rx++; exp_tx++;
    total++; if (irq !== 1'b1 || cmpl_cnt_rx !== 16'(exp_rx) || cmpl_cnt_tx !== 16'(exp_tx)) begin
      bad++; $display("FAIL t3_both_done got irq=%b rx=%0d tx=%0d exp 1/%0d/%0d", irq, cmpl_cnt_rx, cmpl_cnt_tx, exp_rx, exp_tx); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL t3_single_pulse got=%b exp=0", irq); end
  endtask

  task automatic test_len0_misaligned;
    logic acc;
    push(1'b1, 64'h500, 32'd0, acc);
    total++; if (pend_tx !== 3'd1 || bus.start_tx !== 1'b0) begin
      bad++; $display("FAIL t4_len0_queued got pend=%0d start=%b exp 1/0", pend_tx, bus.start_tx); end
    @(negedge clk);
    total++; if (bus.start_tx !== 1'b0 || bus.dst_addr_tx !== 64'h500 || bus.len_pkts_tx !== 32'd0) begin
      bad++; $display("FAIL t4_len0_done got start=%b addr=%h len=%0d", bus.start_tx, bus.dst_addr_tx, bus.len_pkts_tx); end
    @(negedge clk);
    exp_tx++;
    total++; if (bus.start_tx !== 1'b0 || irq !== 1'b1 || cmpl_cnt_tx !== 16'(exp_tx)) begin
      bad++; $display("FAIL t4_len0_count got start=%b irq=%b cnt=%0d exp 0/1/%0d", bus.start_tx, irq, cmpl_cnt_tx, exp_tx); end
    push(1'b0, 64'h104, 32'd1, acc);
    total++; if (acc !== 1'b1 || err !== 1'b1 || pend_rx !== 3'd0) begin
      bad++; $display("FAIL t4_misaligned got acc=%b err=%b pend=%0d exp 1/1/0", acc, err, pend_rx); end
    @(negedge clk);
    total++; if (err !== 1'b1 || bus.start_rx !== 1'b0 || cmpl_cnt_rx !== 16'(exp_rx)) begin
      bad++; $display("FAIL t4_dropped got err=%b start=%b cnt=%0d exp 1/0/%0d", err, bus.start_rx, cmpl_cnt_rx, exp_rx); end
    err_clr = 1'b1;
    push(1'b1, 64'h10C, 32'd4, acc);
    total++; if (err !== 1'b1) begin
      bad++; $display("FAIL t4_set_beats_clr got=%b exp=1", err); end
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (err !== 1'b0 || pend_tx !== 3'd0 || cmpl_cnt_tx !== 16'(exp_tx)) begin
      bad++; $display("FAIL t4_err_clr got err=%b pend=%0d cnt=%0d exp 0/0/%0d", err, pend_tx, cmpl_cnt_tx, exp_tx); end
    irq_en = 1'b0;
    push(1'b1, 64'h508, 32'd0, acc);
    repeat (2) @(negedge clk);
    exp_tx++;
    total++; if (irq !== 1'b0 || cmpl_cnt_tx !== 16'(exp_tx)) begin
      bad++; $display("FAIL t4_irq_masked got irq=%b cnt=%0d exp 0/%0d", irq, cmpl_cnt_tx, exp_tx); end
    irq_en = 1'b1;
  endtask

  task automatic test_flush;
    logic acc;
    push(1'b0, 64'h600, 32'd1, acc);
    push(1'b0, 64'h608, 32'd1, acc);
    push(1'b0, 64'h610, 32'd1, acc);
    total++; if (pend_rx !== 3'd2 || bus.start_rx !== 1'b1 || bus.src_addr_rx !== 64'h600) begin
      bad++; $display("FAIL t5_queued got pend=%0d start=%b addr=%h exp 2/1/600", pend_rx, bus.start_rx, bus.src_addr_rx); end
    man_busy_rx = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    push(1'b0, 64'h618, 32'd1, acc);
    flush = 1'b0;
    total++; if (acc !== 1'b0 || pend_rx !== 3'd0) begin
      bad++; $display("FAIL t5_flush got acc=%b pend=%0d exp 0/0", acc, pend_rx); end
    man_busy_rx = 1'b0;
    repeat (2) @(negedge clk);
    exp_rx++;
    total++; if (cmpl_cnt_rx !== 16'(exp_rx) || idle !== 1'b1) begin
      bad++; $display("FAIL t5_active_done got cnt=%0d idle=%b exp %0d/1", cmpl_cnt_rx, idle, exp_rx); end
    repeat (3) @(negedge clk);
    total++; if (bus.start_rx !== 1'b0 || cmpl_cnt_rx !== 16'(exp_rx)) begin
      bad++; $display("FAIL t5_no_relaunch got start=%b cnt=%0d exp 0/%0d", bus.start_rx, cmpl_cnt_rx, exp_rx); end
  endtask

  task automatic test_reset_launch;
    logic acc;
    push(1'b0, 64'h7, 32'd1, acc);
    push(1'b1, 64'h700, 32'd5, acc);
    @(negedge clk);
    total++; if (bus.start_tx !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL t6_pre got start=%b err=%b exp 1/1", bus.start_tx, err); end
    reset = 1'b1;
    #1;
    total++; if ({bus.start_tx, irq, err, pend_tx, bus.dst_addr_tx, bus.len_pkts_tx, cmpl_cnt_tx, cmpl_cnt_rx} !== '0) begin
      bad++; $display("FAIL t6_reset_clear got start=%b err=%b addr=%h cnt=%0d/%0d exp 0", bus.start_tx, err, bus.dst_addr_tx, cmpl_cnt_rx, cmpl_cnt_tx); end
    total++; if ({bus.desc_ready, idle} !== 2'b11) begin
      bad++; $display("FAIL t6_reset_ready got=%b exp=11", {bus.desc_ready, idle}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.start_tx !== 1'b0 || cmpl_cnt_tx !== 16'd0 || irq !== 1'b0) begin
      bad++; $display("FAIL t6_job_dropped got start=%b cnt=%0d irq=%b exp 0/0/0", bus.start_tx, cmpl_cnt_tx, irq); end
  endtask

  initial begin
    bus.desc_valid = 1'b0; bus.desc_dir = 1'b0; bus.desc_addr = '0; bus.desc_len = '0;
    test_reset();
    test_single_rx();
    test_queue_full();
    test_concurrent();
    test_len0_misaligned();
    test_flush();
    test_reset_launch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
